// File: rtl/mont_pkg.sv
// Shared definitions for the radix-2 Montgomery multiplier: default operand width
// and controller state encoding.
package mont_pkg;

    localparam int unsigned MontWidth = 512;

    typedef enum logic [1:0] {
        StIdle,
        StMult,
        StReduce,
        StDone
    } mont_state_e;

endpackage

// File: rtl/mont_addsub.sv
// Combinational CW-bit datapath: one radix-2 Montgomery step (add, conditional add, halve)
// plus the compare/subtract used during final reduction.
module mont_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = WIDTH + 2
) (
    input  logic [CW-1:0]    c_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] m_i,
    input  logic             a_bit_i,
    output logic [CW-1:0]    mult_o,
    output logic [CW-1:0]    diff_o,
    output logic             ge_o
);

    logic [CW-1:0] b_ext;
    logic [CW-1:0] m_ext;
    logic [CW-1:0] sum_ab;
    logic [CW-1:0] sum_abm;
    logic          q_bit;

    assign b_ext   = CW'(b_i);
    assign m_ext   = CW'(m_i);

    // q is chosen so that the sum is even and the halving is exact.
    assign sum_ab  = c_i + (a_bit_i ? b_ext : '0);
    assign q_bit   = sum_ab[0];
    assign sum_abm = sum_ab + (q_bit ? m_ext : '0);
    assign mult_o  = sum_abm >> 1;

    assign ge_o    = (c_i >= m_ext);
    assign diff_o  = c_i - m_ext;

endmodule

// File: rtl/montgomery_pmul.sv
// Bit-serial Montgomery multiplier: result = a * b * 2^-WIDTH mod m, LSB-first over a,
// followed by repeated conditional subtraction until fully reduced.
module montgomery_pmul
    import mont_pkg::*;
#(
    parameter int unsigned WIDTH = MontWidth,
    parameter int unsigned CW    = WIDTH + 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    localparam int unsigned   IW    = $clog2(WIDTH) + 1;
    localparam logic [IW-1:0] ILast = IW'(WIDTH - 1);

    mont_state_e      state_q, state_d;
    logic [CW-1:0]    c_q, c_d;
    logic [IW-1:0]    i_q, i_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             a_bit;
    logic [CW-1:0]    mult_sum;
    logic [CW-1:0]    sub_diff;
    logic             c_ge_m;

    assign a_bit = |(a_q & (WIDTH'(1) << i_q));

    mont_addsub #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_addsub (
        .c_i     (c_q),
        .b_i     (b_q),
        .m_i     (m_q),
        .a_bit_i (a_bit),
        .mult_o  (mult_sum),
        .diff_o  (sub_diff),
        .ge_o    (c_ge_m)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            c_q      <= '0;
            i_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            result_q <= '0;
        end else begin
            c_q      <= c_d;
            i_q      <= i_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StMult;
            StMult:   if (i_q == ILast) state_d = StReduce;
            StReduce: if (!c_ge_m) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        c_d      = c_q;
        i_d      = i_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d = in_a;
                    b_d = in_b;
                    m_d = in_m;
                    c_d = '0;
                    i_d = '0;
                end
            end
            StMult: begin
                c_d = mult_sum;
                i_d = i_q + 1'b1;
            end
            StReduce: begin
                if (c_ge_m) begin
                    c_d = sub_diff;
                end else begin
                    result_d = c_q[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        done   = (state_q == StDone);
        busy   = (state_q != StIdle);
        result = result_q;
    end

endmodule

// File: doc/montgomery_pmul.md
MONTGOMERY_PMUL -- requirements
Module: montgomery_pmul

Interface
REQ-001 SHALL have parameter WIDTH, default 512, operand/modulus width in bits (even, >= 8).
REQ-002 SHALL have parameter CW, default WIDTH+2, internal accumulator width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin an operation.
REQ-006 SHALL have port in_a  input  WIDTH  multiplicand, any value < 2^WIDTH (need not be < in_m).
REQ-007 SHALL have port in_b  input  WIDTH  multiplier, any value < 2^WIDTH.
REQ-008 SHALL have port in_m  input  WIDTH  modulus, odd, MSB set.
REQ-009 SHALL have port result  output  WIDTH  a*b*2^-WIDTH mod m, fully reduced (< m).
REQ-010 SHALL have port done  output  1  one-cycle pulse when result is valid.
REQ-011 SHALL have port busy  output  1  high from the cycle after start is accepted until the cycle done is high, inclusive.

Function
REQ-012 SHALL implement states IDLE, MULT, REDUCE, DONE.
REQ-013 In IDLE with start=1, SHALL register in_a, in_b, in_m, clear accumulator C, clear bit counter i, go to MULT.
REQ-014 start SHALL be ignored in MULT, REDUCE, DONE; registered operands SHALL NOT change while busy.
REQ-015 Each MULT cycle: C <= (C + a[i]*b + q*m) >> 1, q = LSB of (C + a[i]*b); i increments; radix-2, LSB first.
REQ-016 MULT SHALL last exactly WIDTH cycles, then go to REDUCE.
REQ-017 REDUCE cycle: if C >= m then C <= C - m and stay; else result <= C[WIDTH-1:0], go to DONE.
REQ-018 REDUCE SHALL repeat subtraction as often as needed; for any legal input it SHALL finish within 3 subtractions.
REQ-019 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-020 Latency start-to-done SHALL be WIDTH + s + 2 cycles, s = number of subtractions performed.
REQ-021 result SHALL hold its value from DONE until the next DONE; it SHALL NOT change during a new operation.
REQ-022 start in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-023 All arithmetic on C SHALL use CW bits; no intermediate overflow for legal inputs.

Reset
REQ-024 resetn=0 at a rising edge SHALL force state IDLE, result=0, done=0, busy=0, C=0, i=0.
REQ-025 Reset asserted mid-operation SHALL abort it with no done pulse; next start after release SHALL run normally.
REQ-026 Reset SHALL take priority over start in the same cycle.

Structure
REQ-027 State encoding and default WIDTH constant SHALL reside in shared package mont_pkg.
REQ-028 The CW-bit add/compare/subtract datapath SHALL be one sub-module, mont_addsub, combinational, instantiated once.
REQ-029 Counter width SHALL be $clog2(WIDTH)+1; no other sub-modules.

Verification
REQ-030 WIDTH=8, a=0x05, b=0x07, m=0xF1 -> result=0xA3, one done pulse, busy high throughout.
REQ-031 WIDTH=8, a=0xFF, b=0xFF, m=0x81 (unreduced inputs) -> result=0x3C, s>=1, latency WIDTH+s+2.
REQ-032 WIDTH=8, a=0x00, b=0x9B, m=0xF1 -> result=0x00, s=0, latency exactly 10 cycles.
REQ-033 start re-pulsed at cycle 3 of MULT with different operands -> ignored; result matches first operand set.
REQ-034 resetn=0 for one cycle mid-MULT -> no done, result=0, busy=0; subsequent start of REQ-030 -> 0xA3.
REQ-035 WIDTH=512, 1000 random a,b < 2^512, odd m with MSB set -> result equals golden model a*b*2^-512 mod m, always < m.
